// File: rtl/proc_pkg.sv
// Shared processor-pipeline types: data widths, fetch-unit FSM states and prefetch FIFO entry.
package proc_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   typedef enum logic [1:0] {IDLE, WAIT, SQUASH} ifu_state_t;

   // Decode view of an instruction word: opcode [31:27], func [26:23].
   typedef struct packed {
      logic [4:0]  opcode;
      logic [3:0]  func;
      logic [22:0] rest;
   } instr_fields_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO for the fetch unit: DEPTH x fetch_entry_t, synchronous flush, combinational head.
module ifu_fifo
   import proc_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  fetch_entry_t     data_i,
   output fetch_entry_t     head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // NOTE: storage is not reset; an entry is only visible once count_q says it was written.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         assert (!(pop_i && empty_o));
         assert (!(push_i && full));
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
         else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC and request FSM in front of a prefetch FIFO feeding decode via valid/ready.
// Define IFU_PERF_EN to add the perf_fetched / perf_stall counter outputs.
module instr_fetch_unit
   import proc_pkg::*;
#(
   parameter int              DEPTH   = 4,
   parameter logic [PC_W-1:0] PC_STEP = 32'd4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [PC_W-1:0]    startPC,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
`ifdef IFU_PERF_EN
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall,
`endif
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   ifu_state_t       state_q;
   logic [PC_W-1:0]  fetch_pc_q;
   logic [PC_W-1:0]  mem_addr_q;
   logic             mem_req_q;
   logic             push;
   logic             pop;
   logic             credit;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   // Credit looks only at the current count: a pop this cycle frees a slot for the next request, not this one.
   assign credit     = (fifo_count < CNT_W'(DEPTH));
   assign push       = (state_q == WAIT) && mem_ack && !redirect_valid;
   assign pop        = instr_valid && instr_ready && !redirect_valid;
   assign push_entry = '{pc: mem_addr_q, instr: mem_rdata};

   ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .flush_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_entry),
      .head_o  (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         fetch_pc_q <= startPC;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (redirect_valid) begin
                  fetch_pc_q <= redirect_pc;
               end else if (credit) begin
                  state_q    <= WAIT;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_pc_q;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state_q    <= IDLE;
                  mem_req_q  <= 1'b0;
                  fetch_pc_q <= redirect_valid ? redirect_pc : fetch_pc_q + PC_STEP;
               end else if (redirect_valid) begin
                  state_q    <= SQUASH;
                  fetch_pc_q <= redirect_pc;
               end
            end
            SQUASH: begin
               // The stale request must still complete its handshake; only its data is discarded.
               if (redirect_valid) fetch_pc_q <= redirect_pc;
               if (mem_ack) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr_valid = !fifo_empty;
   assign instr_out   = fifo_empty ? '0 : head.instr;
   assign instr_pc    = fifo_empty ? '0 : head.pc;

`ifdef IFU_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (push)                        perf_fetched_q <= perf_fetched_q + 32'd1;
         if (instr_ready && !instr_valid) perf_stall_q   <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule
